// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default sizes for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_PROG_LEN = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with load, increment and wrap at PROG_LEN.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned PROG_LEN = DEF_PROG_LEN,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  // PC register: load has priority over increment; out-of-range values wrap to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RST_VAL;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= (pc >= LAST) ? '0 : pc + ONE;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches instructions from a combinational ROM and hands them
// to the decoder with a valid/ready handshake.
// Optional: define INSTR_FETCH_COUNT_EN to add a saturating transfer counter
// on output fetch_cnt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned PROG_LEN = DEF_PROG_LEN,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc
`ifdef INSTR_FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_cnt
`endif
);

  fetch_state_t state, state_n;
  logic         pc_load;
  logic         pc_inc;
  logic         capture;
  logic         valid_n;
  logic         xfer;

  assign xfer     = instr_valid & instr_ready;
  assign rom_addr = pc;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, PC control, ROM enable; jump beats halt and transfer
  always_comb begin
    state_n = state;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    valid_n = instr_valid;
    rom_oe  = 1'b0;
    case (state)
      IDLE: begin
        if (jump_en) begin
          pc_load = 1'b1;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (halt) begin
          valid_n = 1'b0;
          state_n = HALT;
        end else begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        rom_oe = 1'b1;
        if (jump_en) begin
          pc_load = 1'b1;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (halt) begin
          valid_n = 1'b0;
          state_n = HALT;
        end else begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        rom_oe = 1'b1;
        if (jump_en) begin
          pc_load = 1'b1;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (xfer) begin
          if (halt) begin
            valid_n = 1'b0;
            state_n = HALT;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
          end
        end
      end
      HALT: begin
        valid_n = 1'b0;
        if (jump_en) begin
          pc_load = 1'b1;
        end else if (!halt) begin
          state_n = FETCH;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // Instruction and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= valid_n;
      if (capture) begin
        instr <= rom_data;
      end
    end
  end

`ifdef INSTR_FETCH_COUNT_EN
  // Saturating count of accepted transfers; a jump discards the held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (xfer && !jump_en && fetch_cnt != '1) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// ROM model: cells 0..15 hold 16'h1000+addr, zero elsewhere or when rom_oe=0.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_oe;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [4:0]  jump_addr;
  logic        halt;
  logic [4:0]  pc;
`ifdef INSTR_FETCH_COUNT_EN
  logic [15:0] fetch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_oe && rom_addr < 5'd16) ? (16'h1000 | {11'd0, rom_addr}) : 16'h0000;

  instr_fetch #(
    .ADDR_W   (5),
    .DATA_W   (16),
    .PROG_LEN (16),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_oe      (rom_oe),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .pc          (pc)
`ifdef INSTR_FETCH_COUNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks instr_valid, instr and pc together
  task automatic chk3(input string tag, input logic v, input logic [15:0] i, input logic [4:0] p);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, ".instr"}, {16'd0, instr}, {16'd0, i});
    chk({tag, ".pc"}, {27'd0, pc}, {27'd0, p});
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 5'd0; halt = 1'b0;
    #1;
    chk3("reset", 1'b0, 16'h0000, 5'd0);
    chk("reset.rom_oe", {31'd0, rom_oe}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;

    // Reset release: IDLE -> FETCH -> first valid
    tick();
    chk3("start.fetch", 1'b0, 16'h0000, 5'd0);
    chk("start.rom_oe", {31'd0, rom_oe}, 32'd1);
    tick();
    chk3("start.first", 1'b1, 16'h1000, 5'd1);
    tick();
    chk3("start.second", 1'b1, 16'h1001, 5'd2);
`ifdef INSTR_FETCH_COUNT_EN
    chk("cnt.one", {16'd0, fetch_cnt}, 32'd1);
`endif
    tick();
    chk3("start.third", 1'b1, 16'h1002, 5'd3);

    // Backpressure at pc=3 for three cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3("stall", 1'b1, 16'h1002, 5'd3);
    end
    instr_ready = 1'b1;
    tick();
    chk3("resume", 1'b1, 16'h1003, 5'd4);

    // Stream up to the wrap point
    for (int k = 1; k <= 12; k++) tick();
    chk3("wrap.last", 1'b1, 16'h100F, 5'd0);
    tick();
    chk3("wrap.first", 1'b1, 16'h1000, 5'd1);
    tick();
    chk3("wrap.next", 1'b1, 16'h1001, 5'd2);

    // Jump during a transfer cycle
    jump_en = 1'b1; jump_addr = 5'd9;
    tick();
    jump_en = 1'b0;
    chk3("jump.bubble", 1'b0, 16'h1001, 5'd9);
    chk("jump.rom_addr", {27'd0, rom_addr}, 32'd9);
    tick();
    chk3("jump.target", 1'b1, 16'h1009, 5'd10);

    // Halt in HOLD waits for a transfer
    halt = 1'b1; instr_ready = 1'b0;
    tick();
    chk3("halt.wait", 1'b1, 16'h1009, 5'd10);
    chk("halt.wait.rom_oe", {31'd0, rom_oe}, 32'd1);
    instr_ready = 1'b1;
    tick();
    chk3("halt.enter", 1'b0, 16'h1009, 5'd10);
    chk("halt.enter.rom_oe", {31'd0, rom_oe}, 32'd0);
    tick();
    chk3("halt.stay", 1'b0, 16'h1009, 5'd10);
    halt = 1'b0;
    tick();
    chk3("halt.fetch", 1'b0, 16'h1009, 5'd10);
    chk("halt.fetch.rom_oe", {31'd0, rom_oe}, 32'd1);
    tick();
    chk3("halt.resume", 1'b1, 16'h100A, 5'd11);

    // Jump beyond program length: loads as-is, reads zero, then wraps
    jump_en = 1'b1; jump_addr = 5'd20;
    tick();
    jump_en = 1'b0;
    chk3("oor.load", 1'b0, 16'h100A, 5'd20);
    tick();
    chk3("oor.data", 1'b1, 16'h0000, 5'd0);
    tick();
    chk3("oor.wrap", 1'b1, 16'h1000, 5'd1);

    // Stream to pc=7, then asynchronous reset mid-cycle
    for (int k = 0; k < 6; k++) tick();
    chk3("pre_rst", 1'b1, 16'h1006, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    chk3("async_rst", 1'b0, 16'h0000, 5'd0);
    chk("async_rst.rom_oe", {31'd0, rom_oe}, 32'd0);
`ifdef INSTR_FETCH_COUNT_EN
    chk("cnt.rst", {16'd0, fetch_cnt}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk3("restart.fetch", 1'b0, 16'h0000, 5'd0);
    tick();
    chk3("restart.first", 1'b1, 16'h1000, 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: ADDR_W 5, instruction-memory address width; DATA_W 16, instruction width; PROG_LEN 16, number of program cells, wrap point; RESET_PC 0, PC value after reset.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rom_oe  out  1  instruction-memory output enable.
- rom_addr  out  ADDR_W  instruction-memory address.
- rom_data  in  DATA_W  combinational read data; zero when rom_oe=0.
- instr  out  DATA_W  fetched instruction to decoder.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decoder accepts instr.
- jump_en  in  1  load PC from jump_addr.
- jump_addr  in  ADDR_W  jump target.
- halt  in  1  stop fetching.
- pc  out  ADDR_W  address of the next fetch.

Function
REQ-003 Handshake: a transfer SHALL occur on a rising edge where instr_valid=1 and instr_ready=1; instr SHALL stay stable while instr_valid=1 and no transfer occurs.
REQ-004 The FSM SHALL have states IDLE, FETCH, HOLD and HALT.
REQ-005 IDLE: rom_oe=0; next state SHALL be FETCH, or HALT if halt=1.
REQ-006 FETCH: rom_oe=1, rom_addr=pc; on the edge: instr<=rom_data, instr_valid<=1, pc increments, next state HOLD; first valid SHALL appear 1 cycle after entering FETCH.
REQ-007 HOLD: rom_oe=1, rom_addr=pc; on a transfer: instr<=rom_data and pc increments, sustaining 1 instruction/cycle; no transfer -> all registers hold.
REQ-008 PC increment SHALL wrap: pc >= PROG_LEN-1 -> 0, otherwise pc+1.
REQ-009 jump_en=1 in IDLE, FETCH or HOLD: pc<=jump_addr, instr_valid<=0, next state FETCH; jump_en SHALL win over a simultaneous transfer, and the held instruction is discarded.
REQ-010 jump_addr >= PROG_LEN SHALL load unchanged; the memory returns 0 there, and the next increment wraps pc to 0.
REQ-011 halt=1 in IDLE or FETCH: next state HALT, instr_valid<=0, pc unchanged, nothing captured.
REQ-012 halt=1 in HOLD: takes effect only on a transfer edge; then next state HALT, instr_valid<=0, pc unchanged. Without a transfer, remain in HOLD.
REQ-013 HALT: rom_oe=0, instr_valid=0; halt=0 -> FETCH at the current pc; jump_en in HALT SHALL load pc and remain in HALT.
REQ-014 rom_addr SHALL equal pc in every state.

Reset
REQ-015 rst=1 SHALL immediately force: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, rom_oe=0.
REQ-016 rst asserted mid-operation SHALL discard any held instruction; after release, fetch SHALL restart from RESET_PC.

Configuration
REQ-017 Macro INSTR_FETCH_COUNT_EN defined: adds output port fetch_cnt (16 bits), counting transfers, reset to 0, saturating at 16'hFFFF.
REQ-018 Macro not defined: port fetch_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-019 Package fetch_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and the RESET_PC constant.
REQ-020 The PC SHALL be a sub-module fetch_pc: load, increment and wrap at PROG_LEN.

Verification
(Memory cells 0..15 = 16'h1000+addr.)
REQ-021 Reset release, instr_ready=1 -> instr_valid first high 2 cycles after release with instr=16'h1000; then 16'h1001, 16'h1002 on consecutive cycles.
REQ-022 instr_ready=0 for 3 cycles at pc=3 -> instr stays 16'h1002, pc stays 3; resumes with 16'h1003.
REQ-023 Continuous ready through address 15 -> 16'h100F followed by 16'h1000, pc wraps 15->0.
REQ-024 jump_en with jump_addr=9 during a transfer cycle -> instr_valid low 1 cycle, next instr=16'h1009.
REQ-025 halt in HOLD with ready=0 -> state stays HOLD; ready=1 -> transfer, then instr_valid=0, rom_oe=0; halt=0 -> next instr from the preserved pc.
REQ-026 rst pulse mid-stream at pc=7 -> instr_valid=0 asynchronously; restart at 16'h1000; with INSTR_FETCH_COUNT_EN, fetch_cnt returns to 0.
